alu8_core: RTL and testbench

Sequential 8-bit ALU combining a control FSM and a datapath (accumulator A, multiplier/quotient Q, operand M, iteration counter, adder/subtractor). It performs signed add, signed subtract, signed radix-4 Booth multiply and unsigned restoring divide. A `bgn` pulse starts an operation, and `endd` marks a valid 16-bit result on `outbus`. It is the arithmetic engine instantiated by the top-level processor.

---
 rtl/alu8_core.sv | 152 +++++++++++++++
 tb/tb_alu8_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu8_core.sv
// Sequential 8-bit ALU: signed add/sub, radix-4 Booth signed multiply and
// unsigned restoring divide, sequenced by a four-state control FSM.
module alu8_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        bgn,
  input  logic [1:0]  op,
  input  logic [7:0]  operand1,
  input  logic [7:0]  operand2,
  output logic [15:0] outbus,
  output logic        endd
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StOut, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [9:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  m_q, m_d;
  logic        qm1_q, qm1_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] outbus_q, outbus_d;
  logic        endd_q, endd_d;

  logic [8:0]  addsub;
  logic [9:0]  m_ext;
  logic [9:0]  booth_term;
  logic [9:0]  booth_sum;
  logic [9:0]  div_shift;
  logic [9:0]  div_diff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      outbus_q <= '0;
      endd_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      outbus_q <= outbus_d;
      endd_q   <= endd_d;
    end
  end

  // Datapath arithmetic, shared by the EXEC branches below.
  always_comb begin
    addsub = (op_q == OpSub) ? ({q_q[7], q_q} - {m_q[7], m_q})
                             : ({q_q[7], q_q} + {m_q[7], m_q});
    m_ext  = {{2{m_q[7]}}, m_q};
    booth_term = '0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: booth_term = m_ext;
      3'b011:         booth_term = m_ext << 1;
      3'b100:         booth_term = -(m_ext << 1);
      3'b101, 3'b110: booth_term = -m_ext;
      default:        booth_term = '0;
    endcase
    booth_sum = a_q + booth_term;
    div_shift = {a_q[8:0], q_q[7]};
    div_diff  = div_shift - {2'b00, m_q};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    outbus_d = outbus_q;
    endd_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bgn) begin
          op_d  = op;
          a_d   = '0;
          qm1_d = 1'b0;
          cnt_d = '0;
          if (op == OpMul) begin
            m_d = operand1;
            q_d = operand2;
          end else begin
            q_d = operand1;
            m_d = operand2;
          end
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (op_q)
          OpAdd, OpSub: begin
            a_d     = {addsub[8], addsub};
            state_d = StOut;
          end
          OpMul: begin
            // Arithmetic shift of {A, Q, q-1} right by two after the add.
            a_d   = {{2{booth_sum[9]}}, booth_sum[9:2]};
            q_d   = {booth_sum[1:0], q_q[7:2]};
            qm1_d = q_q[1];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd3) state_d = StOut;
          end
          OpDiv: begin
            if (div_diff[9]) begin
              a_d = div_shift;
              q_d = {q_q[6:0], 1'b0};
            end else begin
              a_d = div_diff;
              q_d = {q_q[6:0], 1'b1};
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = StOut;
          end
        endcase
      end
      StOut: begin
        if (op_q == OpAdd || op_q == OpSub) begin
          outbus_d = {{7{a_q[8]}}, a_q[8:0]};
        end else begin
          outbus_d = {a_q[7:0], q_q};
        end
        state_d = StDone;
      end
      StDone: begin
        endd_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  assign outbus = outbus_q;
  assign endd   = endd_q;

endmodule

// File: tb/tb_alu8_core.sv
// Randomized scoreboard bench for alu8_core: driver queues expected results,
// a negedge monitor pops one entry per endd pulse and checks value and latency.
module tb_alu8_core;

  logic        clk;
  logic        rst;
  logic        bgn;
  logic [1:0]  op;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic [15:0] outbus;
  logic        endd;

  alu8_core dut (
    .clk      (clk),
    .rst      (rst),
    .bgn      (bgn),
    .op       (op),
    .operand1 (operand1),
    .operand2 (operand2),
    .outbus   (outbus),
    .endd     (endd)
  );

  typedef struct {
    logic [15:0] val;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  function automatic logic [15:0] model(input logic [1:0] o, input logic [7:0] a,
                                        input logic [7:0] b);
    int sa;
    int sb_;
    int r;
    sa  = $signed(a);
    sb_ = $signed(b);
    r   = 0;
    case (o)
      2'd0: r = sa + sb_;
      2'd1: r = sa - sb_;
      2'd2: r = sa * sb_;
      default: begin
        if (b == 8'd0) return {a, 8'hFF};
        return {8'(a % b), 8'(a / b)};
      end
    endcase
    return r[15:0];
  endfunction

  function automatic int latency(input logic [1:0] o);
    return (o < 2'd2) ? 3 : (o == 2'd2) ? 6 : 10;
  endfunction

  always @(negedge clk) begin
    if (endd) begin
      if (sb.size() == 0) begin
        check("spurious_endd", 32'(endd), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(outbus), 32'(e.val));
        check("latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  // One operation; inputs (and bgn) are scrambled while the DUT is busy.
  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    bgn = 1'b1; op = o; operand1 = a; operand2 = b;
    e.val = model(o, a, b); e.start = cyc + 1; e.lat = latency(o);
    sb.push_back(e);
    for (int k = 0; k < latency(o); k++) begin
      @(negedge clk);
      bgn      = 1'($urandom_range(0, 1));
      op       = 2'($urandom_range(0, 3));
      operand1 = 8'($urandom_range(0, 255));
      operand2 = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    bgn = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; bgn = 1'b0; op = 2'd0; operand1 = 8'd0; operand2 = 8'd0;
    #12;
    check("reset_outbus", 32'(outbus), 32'd0);
    check("reset_endd", 32'(endd), 32'd0);
    rst = 1'b1;

    issue(2'd0, 8'd100, 8'd27);
    issue(2'd0, 8'h80, 8'h80);
    issue(2'd0, 8'd127, 8'd127);
    issue(2'd1, 8'd5, 8'd10);
    issue(2'd1, 8'h80, 8'd127);
    issue(2'd2, 8'hF9, 8'd13);
    issue(2'd2, 8'h80, 8'h80);
    issue(2'd2, 8'd127, 8'h80);
    issue(2'd3, 8'd144, 8'd5);
    issue(2'd3, 8'd255, 8'd1);
    issue(2'd3, 8'd7, 8'd0);

    // Reset during divide iteration 4 must abort silently.
    @(negedge clk);
    bgn = 1'b1; op = 2'd3; operand1 = 8'd200; operand2 = 8'd3;
    @(negedge clk);
    bgn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_outbus", 32'(outbus), 32'd0);
    check("abort_endd", 32'(endd), 32'd0);
    #1 rst = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_outbus_hold", 32'(outbus), 32'd0);
    issue(2'd3, 8'd200, 8'd3);

    // bgn held high: two back-to-back operations, one endd each.
    @(negedge clk);
    bgn = 1'b1; op = 2'd2; operand1 = 8'd11; operand2 = 8'hF3;
    e.val = model(2'd2, 8'd11, 8'hF3); e.lat = 6;
    e.start = cyc + 1; sb.push_back(e);
    e.start = cyc + 1 + 7; sb.push_back(e);
    repeat (13) @(negedge clk);
    bgn = 1'b0;

    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (6) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
